// File: rtl/uart_deframer.sv
// uart_deframer: parses SYNC/LEN/payload/CHK frames popped from the uart RX FIFO.
// The payload is buffered and released as a valid/ready byte stream only once the
// checksum has passed. Corrupt or partial frames never reach downstream.
// Optional feature: define UART_DEFRAMER_TIMEOUT_EN to drop a frame whose bytes
// stop arriving for TIMEOUT clk cycles.
module uart_deframer #(
  parameter int               DATA_   = 8,
  parameter int               MAXLEN  = 16,
  parameter logic [DATA_-1:0] SYNC    = 8'hA5,
  parameter int               TIMEOUT = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rxavail,
  output logic                         re,
  input  logic [DATA_-1:0]             rxdata,
  output logic [DATA_-1:0]             dout,
  output logic                         valid,
  input  logic                         ready,
  output logic                         last,
  output logic [$clog2(MAXLEN+1)-1:0]  len,
  output logic                         ok,
  output logic                         err,
  output logic                         busy
);

  localparam int LW = $clog2(MAXLEN + 1);
  localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_CHECK, S_EMIT} state_t;

  state_t           state, state_d;
  logic             pend;
  logic             cap;
  logic             tmo;
  logic             len_bad;
  logic             ok_d, err_d;
  logic [DATA_-1:0] b;
  logic [DATA_-1:0] sum, sum_nx;
  logic [LW-1:0]    cnt, idx;
  logic [DATA_-1:0] pbuf [MAXLEN];

  assign b       = rxdata;
  assign sum_nx  = sum + b;
  assign len_bad = (b == '0) || (32'(b) > 32'(MAXLEN));
  assign busy    = (state != S_SYNC);

  // One read in flight at most; the FIFO holds bytes while a frame is being emitted.
  assign re = !rst && rxavail && !pend && (state != S_EMIT);

`ifdef UART_DEFRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          disc;
  logic          parsing;

  assign parsing = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
  assign tmo     = parsing && !pend && (tcnt == TW'(TIMEOUT - 1));
  // A read launched in the same cycle as a timeout returns a byte that must be ignored.
  assign cap     = pend && !disc;

  // Inter-byte idle counter and the discard flag for a read racing the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      disc <= 1'b0;
    end else begin
      if (pend || !parsing || tmo) tcnt <= '0;
      else                         tcnt <= tcnt + TW'(1);
      if (tmo && re)  disc <= 1'b1;
      else if (pend)  disc <= 1'b0;
    end
  end
`else
  assign cap = pend;
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_SYNC;
    else     state <= state_d;
  end

  // Next-state and ok/err pulse decisions, advanced by captured bytes.
  always_comb begin
    state_d = state;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state)
      S_SYNC:    if (cap && b == SYNC) state_d = S_LEN;
      S_LEN: begin
        if (cap) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: if (cap && (cnt + LW'(1)) == len) state_d = S_CHECK;
      S_CHECK: begin
        if (cap) begin
          if (sum_nx == '0) begin
            ok_d    = 1'b1;
            state_d = S_EMIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end
        end
      end
      S_EMIT:    if (valid && ready && last) state_d = S_SYNC;
      default:   state_d = S_SYNC;
    endcase
    if (tmo) begin
      err_d   = 1'b1;
      state_d = S_SYNC;
    end
  end

  // Control and output registers: read tracking, pulses, length and the emit stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      ok    <= 1'b0;
      err   <= 1'b0;
      valid <= 1'b0;
      last  <= 1'b0;
      dout  <= '0;
      len   <= '0;
    end else begin
      pend <= re;
      ok   <= ok_d;
      err  <= err_d;
      if (state == S_LEN && cap && !len_bad) len <= LW'(b);
      if (state == S_EMIT) begin
        if (!valid) begin
          valid <= 1'b1;
          dout  <= pbuf[IW'(idx)];
          last  <= (idx + LW'(1)) == len;
        end else if (ready) begin
          if (last) begin
            valid <= 1'b0;
            last  <= 1'b0;
          end else begin
            dout <= pbuf[IW'(idx + LW'(1))];
            last <= (idx + LW'(2)) == len;
          end
        end
      end
    end
  end

  // Payload buffer, running checksum and byte counters.
  always_ff @(posedge clk) begin
    if (cap) begin
      case (state)
        S_SYNC: sum <= '0;
        S_LEN: begin
          sum <= b;
          cnt <= '0;
        end
        S_PAYLOAD: begin
          pbuf[IW'(cnt)] <= b;
          sum            <= sum_nx;
          cnt            <= cnt + LW'(1);
        end
        default: ;
      endcase
    end
    if (ok_d)                                        idx <= '0;
    else if (state == S_EMIT && valid && ready && !last) idx <= idx + LW'(1);
  end

endmodule

// File: tb/tb_uart_deframer.sv
// Bench for uart_deframer: a queue-backed uart FIFO feeds the DUT, a frame-level
// reference model predicts ok/err counts and payload beats, and a monitor checks
// handshakes, backpressure holding and pulse rules every cycle.
module tb_uart_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxavail = 1'b0;
  logic       re;
  logic [7:0] rxdata = 8'h00;
  logic [7:0] dout;
  logic       valid;
  logic       ready = 1'b1;
  logic       last;
  logic [4:0] len;
  logic       ok;
  logic       err;
  logic       busy;

  uart_deframer #(.DATA_(8), .MAXLEN(16), .SYNC(8'hA5), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rxavail(rxavail), .re(re), .rxdata(rxdata),
    .dout(dout), .valid(valid), .ready(ready), .last(last), .len(len),
    .ok(ok), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [4:0] n;
  } beat_t;

  int         checks = 0;
  int         errors = 0;
  int         ok_cnt = 0;
  int         err_cnt = 0;
  int         rdy_mode = 0;
  int         stall = 0;
  logic [7:0] fifo [$];
  logic [7:0] seg [$];
  beat_t      expq [$];
  beat_t      eb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // uart RX FIFO model: dout is valid the cycle after re.
  always @(posedge clk) begin
    if (re) begin
      chk("re_when_empty", (fifo.size() > 0), 1);
      if (fifo.size() > 0) begin
        rxdata <= fifo[0];
        void'(fifo.pop_front());
      end
    end
    rxavail <= (fifo.size() > 0);
  end

  // Downstream ready: always, random, or a 5-cycle stall on beat 8'h22.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 9) < 7);
        default: begin
          if (valid && dout == 8'h22 && stall < 5) begin
            ready = 1'b0;
            stall++;
          end else begin
            ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Cycle monitor.
  logic       p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_ok = 1'b0;
  logic [7:0] p_dout = 8'h00;
  logic [4:0] p_len = 5'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ok) ok_cnt++;
      if (err) err_cnt++;
      if (ok || err) chk("ok_err_excl", (ok & err), 0);
      if (ok) chk("valid_at_ok", valid, 0);
      if (p_ok) chk("valid_after_ok", valid, 1);
      if (re) chk("re_in_emit", valid, 0);
      if (p_valid && !p_ready) begin
        chk("hold_valid", valid, 1);
        chk("hold_dout", dout, p_dout);
        chk("hold_last", last, p_last);
        chk("hold_len", len, p_len);
      end
      if (valid && ready) begin
        if (expq.size() == 0) begin
          chk("extra_beat", dout, 32'hFFFF);
        end else begin
          eb = expq.pop_front();
          chk("beat_dout", dout, eb.d);
          chk("beat_last", last, eb.l);
          chk("beat_len", len, eb.n);
        end
      end
    end
    p_valid = valid && !rst;
    p_ready = ready;
    p_last  = last;
    p_dout  = dout;
    p_len   = len;
    p_ok    = ok && !rst;
  end

  task automatic push(input logic [7:0] v);
    seg.push_back(v);
  endtask

  task automatic add_f1();
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
  endtask

  task automatic add_frame(input int l, input bit good);
    int s;
    logic [7:0] v;
    push(8'hA5);
    push(8'(l));
    s = l;
    for (int k = 0; k < l; k++) begin
      v = 8'($urandom_range(0, 255));
      push(v);
      s += v;
    end
    if (good) push(8'((256 - (s % 256)) % 256));
    else      push(8'((256 - (s % 256) + $urandom_range(1, 255)) % 256));
  endtask

  task automatic add_garbage(input int n);
    logic [7:0] v;
    for (int k = 0; k < n; k++) begin
      v = 8'($urandom_range(0, 255));
      if (v == 8'hA5) v = 8'h5A;
      push(v);
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int c = 0; c < 20000 && quiet < 6; c++) begin
      @(negedge clk);
      if (fifo.size() == 0 && !rxavail && !busy && !valid && !re) quiet++;
      else quiet = 0;
    end
    chk({tag, "_idle"}, (quiet >= 6), 1);
  endtask

  // Frame-level model over the byte list, then drive the bytes and compare.
  task automatic run_seg(input string tag);
    int i = 0;
    int n = seg.size();
    int eok = 0, eerr = 0, l, s;
    int ok0 = ok_cnt, err0 = err_cnt;
    beat_t bt;
    while (i < n) begin
      if (seg[i] != 8'hA5) begin
        i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        l = seg[i+1];
        if (l == 0 || l > 16) begin
          eerr++;
          i += 2;
        end else if (i + 2 + l >= n) begin
          i = n;
        end else begin
          s = l;
          for (int k = 0; k <= l; k++) s += seg[i+2+k];
          if (s % 256 == 0) begin
            eok++;
            for (int k = 0; k < l; k++) begin
              bt.d = seg[i+2+k];
              bt.l = (k == l - 1);
              bt.n = 5'(l);
              expq.push_back(bt);
            end
          end else begin
            eerr++;
          end
          i += l + 3;
        end
      end
    end
    foreach (seg[k]) fifo.push_back(seg[k]);
    seg.delete();
    wait_idle(tag);
    chk({tag, "_ok"}, ok_cnt - ok0, eok);
    chk({tag, "_err"}, err_cnt - err0, eerr);
    chk({tag, "_beats_left"}, expq.size(), 0);
    expq.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_re"}, re, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_len"}, len, 0);
    chk({tag, "_ok"}, ok, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int ok0, err0, pick;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    add_f1();
    run_seg("basic");

    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
    add_f1();
    run_seg("badchk");

    push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h5A); push(8'hA5);
    run_seg("chk_is_sync");

    push(8'hA5); push(8'h00); push(8'hA5); push(8'h11);
    add_f1();
    run_seg("badlen");

    rdy_mode = 2;
    stall = 0;
    add_f1();
    add_f1();
    run_seg("stall");
    chk("stall_cycles", stall, 5);
    rdy_mode = 0;

    // Reset in the middle of a frame.
    ok0 = ok_cnt;
    err0 = err_cnt;
    fifo.push_back(8'hA5); fifo.push_back(8'h03); fifo.push_back(8'h11);
    repeat (12) @(negedge clk);
    chk("mid_busy", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_ok", ok_cnt - ok0, 0);
    chk("midrst_err", err_cnt - err0, 0);
    add_f1();
    run_seg("after_rst");

`ifdef UART_DEFRAMER_TIMEOUT_EN
    ok0 = ok_cnt;
    err0 = err_cnt;
    fifo.push_back(8'hA5); fifo.push_back(8'h03); fifo.push_back(8'h11);
    repeat (140) @(negedge clk);
    chk("to_err", err_cnt - err0, 1);
    chk("to_ok", ok_cnt - ok0, 0);
    chk("to_busy", busy, 0);
    add_f1();
    run_seg("after_to");
`endif

    rdy_mode = 1;
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 4; k++) begin
        pick = $urandom_range(0, 9);
        if (pick < 5)      add_frame($urandom_range(1, 16), 1'b1);
        else if (pick < 7) add_frame($urandom_range(1, 16), 1'b0);
        else if (pick < 8) begin
          push(8'hA5);
          if ($urandom_range(0, 1) == 0) push(8'h00);
          else push(8'($urandom_range(17, 255)));
        end else add_garbage($urandom_range(1, 4));
      end
      run_seg("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
